multicore_system_ram_port_arbiter: RTL and testbench
====================================================

# multicore_system_ram_port_arbiter

Round-robin arbiter that shares the second (s2) port of a core's dual-port 4096x32 on-chip memory among several Avalon-MM masters (debug/loader DMA, neighbour cores, mailbox logic). It grants one read or write per cycle and drives the memory's s2 port signals. Because the memory's s2 output is unregistered, a read is returned one cycle after its grant on a per-master readdatavalid strobe. The arbiter also honours the memory's reset_req clock-enable gating.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- ADDR_W, 12, word address width
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- reset_req  in  1  memory clock-enable gate; high blocks new grants
- m_address  in  NUM_MASTERS*ADDR_W  per-master word address, master k at slice k
- m_read  in  NUM_MASTERS  per-master read request
- m_write  in  NUM_MASTERS  per-master write request
- m_byteenable  in  NUM_MASTERS*DATA_W/8  per-master byte enables
- m_writedata  in  NUM_MASTERS*DATA_W  per-master write data
- m_waitrequest  out  NUM_MASTERS  per-master stall; low only in the granted cycle
- m_readdata  out  DATA_W  shared read data, qualified by m_readdatavalid
- m_readdatavalid  out  NUM_MASTERS  one-hot read-return strobe
- ram_address  out  ADDR_W  to memory address2
- ram_chipselect  out  1  to chipselect2
- ram_write  out  1  to write2
- ram_byteenable  out  DATA_W/8  to byteenable2
- ram_writedata  out  DATA_W  to writedata2
- ram_clken  out  1  to clken2
- ram_readdata  in  DATA_W  from readdata2

## Operation
- Request k is valid when m_read[k] | m_write[k]. If both are high, write wins and read is ignored for that cycle.
- Arbitration is combinational every cycle. Priority pointer ptr is registered, resets to 0, and is searched ptr, ptr+1, … modulo NUM_MASTERS. The first valid requester is granted, one-hot grant[k].
- No grant is issued while reset_req=1 or reset=1.
- On a grant to k:
  - m_waitrequest[k]=0.
  - ram_* signals carry master k's address, byteenable and writedata.
  - ram_chipselect=1, ram_write=m_write[k].
  - ptr <= (k+1) mod NUM_MASTERS at the clock edge.
- With no grant: ram_chipselect=0, ram_write=0, ram_address/byteenable/writedata hold master ptr's values, and ptr is unchanged.
- All non-granted masters see m_waitrequest=1. With no requests, m_waitrequest is all 1.
- Read tracking: registers rd_pend (1 bit) and rd_id (index), both reset 0. They load rd_pend <= granted & read, rd_id <= k.
- m_readdatavalid = rd_pend ? onehot(rd_id) : 0. m_readdata = ram_readdata passthrough.
- ram_clken = ~reset_req. Writes commit at the grant edge.
- Back-to-back grants are allowed, including read after write to the same address. Read-during-write on the other port is DONT_CARE and is not resolved here.

## Timing
- Grant, waitrequest and ram_* are combinational from requests and ptr in cycle N.
- Read granted in N: m_readdatavalid[k]=1 in N+1 only, with data. Latency is exactly 1.
- A write completes in cycle N, the cycle its waitrequest is low.
- Throughput is 1 access/cycle. With all masters requesting continuously, each is granted exactly once every NUM_MASTERS cycles.
- reset_req rising in cycle N blocks the grant in N. A read granted in N-1 still returns valid in N, because it was captured at the N-1→N edge.
- reset_req falling in cycle N allows a grant in N.
- Reset asserted mid-read drops the pending readdatavalid asynchronously.
- Reset values: ptr=0, rd_pend=0, rd_id=0, m_readdatavalid=0, m_waitrequest=all 1, ram_chipselect=0, ram_write=0.

## Structure
- Package multicore_system_arb_pkg holds:
  - the one-hot-to-index function
  - the rotate-priority helper
  - localparam BE_W = DATA_W/8
- Sub-module multicore_system_rr_picker: combinational request+ptr → one-hot grant and index. It is reused by the mailbox arbiter.
- The top level holds ptr, the read-return pipe and the output muxes.

## Test plan
- Single master 2 writes 0xDEADBEEF to address 0x123 with be=4'b1111, then reads 0x123 → waitrequest[2] low one cycle each; readdatavalid[2] high the cycle after the read grant with 0xDEADBEEF.
- All 4 masters read continuously from reset → grants 0,1,2,3,0,…; each readdatavalid one-hot matches the grant delayed one cycle.
- Master 1 issues a byte write be=4'b0010 with data 0x0000AB00 over a word holding 0x11223344, then reads it → 0x1122AB44.
- Masters 0 and 3 request with ptr=1 → master 3 is granted first and ptr becomes 0, then master 0 is granted.
- reset_req pulsed high for 3 cycles while master 0 requests → waitrequest[0]=1 and ram_clken=0 for those 3 cycles; a read granted just before the pulse still returns valid; the grant resumes in the cycle reset_req falls.
- reset asserted the cycle after a read grant → readdatavalid stays 0 and ptr returns to 0.

Source files
------------

// File: rtl/multicore_system_arb_pkg.sv
// Shared helpers for the multicore system arbiters: priority rotation and
// one-hot decoding, sized for up to MAX_MASTERS requesters.
package multicore_system_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned BE_W        = DEF_DATA_W / 8;

  // Lowest set bit wins if more than one bit is set; callers pass a one-hot vector.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Rotate the low n bits of v right by sh so bit 0 of the result is request sh.
  function automatic logic [MAX_MASTERS-1:0] rotate_prio(input logic [MAX_MASTERS-1:0] v,
                                                         input int unsigned sh,
                                                         input int unsigned n);
    logic [MAX_MASTERS-1:0] r;
    int unsigned            src;
    r = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (i < n) begin
        src = i + sh;
        if (src >= n) src = src - n;
        r[i] = v[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multicore_system_arb_rr_picker.sv
// Combinational round-robin picker: first valid request at or after ptr,
// returned as both a one-hot grant and an index.
module multicore_system_rr_picker
  import multicore_system_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx,
  output logic            grant_valid
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] req_rot;
  logic [MAX_MASTERS-1:0] first;
  int unsigned            idx;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    req_rot        = rotate_prio(req_ext, 32'(ptr), N);
    // Isolate the lowest set bit of the rotated vector.
    first          = req_rot & (~req_rot + MAX_MASTERS'(1));
    idx            = 32'(ptr) + 32'(onehot_to_idx(first));
    if (idx >= N) idx = idx - N;
    grant_valid    = |req_rot;
    grant_idx      = IdxW'(idx);
    grant          = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/multicore_system_ram_port_arbiter.sv
// Round-robin arbiter sharing the s2 port of a 4096x32 on-chip RAM between
// Avalon-MM masters; reads return one cycle after grant on a per-master strobe.
module multicore_system_ram_port_arbiter
  import multicore_system_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            reset_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]               m_readdata,
  output logic [NUM_MASTERS-1:0]          m_readdatavalid,
  output logic [ADDR_W-1:0]               ram_address,
  output logic                            ram_chipselect,
  output logic                            ram_write,
  output logic [DATA_W/8-1:0]             ram_byteenable,
  output logic [DATA_W-1:0]               ram_writedata,
  output logic                            ram_clken,
  input  logic [DATA_W-1:0]               ram_readdata
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);
  localparam int unsigned BeW  = DATA_W / 8;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic [IdxW-1:0]        grant_idx;
  logic                   grant_valid;
  logic [IdxW-1:0]        sel;
  logic [IdxW-1:0]        ptr;
  logic                   rd_pend;
  logic [IdxW-1:0]        rd_id;

  // Clock-enable gating and reset both suppress arbitration entirely.
  assign req = (reset | reset_req) ? '0 : (m_read | m_write);

  multicore_system_rr_picker #(
    .N    (NUM_MASTERS),
    .IdxW (IdxW)
  ) u_picker (
    .req         (req),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Idle cycles park the RAM port on master ptr's signals.
  assign sel = grant_valid ? grant_idx : ptr;

  always_comb begin
    ram_address     = m_address[32'(sel)*ADDR_W +: ADDR_W];
    ram_byteenable  = m_byteenable[32'(sel)*BeW +: BeW];
    ram_writedata   = m_writedata[32'(sel)*DATA_W +: DATA_W];
    ram_chipselect  = grant_valid;
    ram_write       = grant_valid & m_write[sel];
    ram_clken       = ~reset_req;
    m_waitrequest   = ~grant;
    m_readdata      = ram_readdata;
    m_readdatavalid = '0;
    if (rd_pend) m_readdatavalid[rd_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      rd_pend <= 1'b0;
      rd_id   <= '0;
    end else begin
      // Write wins when a master raises both read and write.
      rd_pend <= grant_valid & m_read[grant_idx] & ~m_write[grant_idx];
      if (grant_valid) begin
        rd_id <= grant_idx;
        ptr   <= (grant_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : grant_idx + IdxW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicore_system_ram_port_arbiter.sv
// Bench for the RAM port arbiter: directed scenarios then random traffic, all
// checked against a cycle-level round-robin reference model.
module tb_multicore_system_ram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            reset_req = 1'b0;
  logic [N*AW-1:0] m_address = '0;
  logic [N-1:0]    m_read = '0;
  logic [N-1:0]    m_write = '0;
  logic [N*4-1:0]  m_byteenable = '0;
  logic [N*DW-1:0] m_writedata = '0;
  logic [N-1:0]    m_waitrequest;
  logic [DW-1:0]   m_readdata;
  logic [N-1:0]    m_readdatavalid;
  logic [AW-1:0]   ram_address;
  logic            ram_chipselect;
  logic            ram_write;
  logic [3:0]      ram_byteenable;
  logic [DW-1:0]   ram_writedata;
  logic            ram_clken;
  logic [DW-1:0]   ram_readdata = '0;

  multicore_system_ram_port_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .reset_req       (reset_req),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_byteenable    (m_byteenable),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .ram_address     (ram_address),
    .ram_chipselect  (ram_chipselect),
    .ram_write       (ram_write),
    .ram_byteenable  (ram_byteenable),
    .ram_writedata   (ram_writedata),
    .ram_clken       (ram_clken),
    .ram_readdata    (ram_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[b*8 +: 8] = d[b*8 +: 8];
    return o;
  endfunction

  // Synchronous RAM: address registered, output unregistered -> data next cycle.
  logic [31:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_clken && ram_chipselect) begin
        if (ram_write) mem[ram_address] <= merge(mem[ram_address], ram_writedata, ram_byteenable);
        else           ram_readdata     <= mem[ram_address];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [4096];
  int          mptr;
  bit          mrd_pend;
  int          mrd_id;
  logic [31:0] mrd_data;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic rd, input logic wr, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    m_read[k]             = rd;
    m_write[k]            = wr;
    m_address[k*AW +: AW] = a;
    m_byteenable[k*4 +: 4] = be;
    m_writedata[k*DW +: DW] = d;
  endtask

  task automatic clear_req();
    m_read  = '0;
    m_write = '0;
  endtask

  // Called #1 after a rising edge with inputs already driven; returns #1 after the next edge.
  task automatic step();
    int          g;
    int          k;
    int          s;
    logic [3:0]  exp_wait;
    logic [3:0]  exp_rdv;
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    bit          wr;
    bit          rd;
    #3;
    g = -1;
    if (!reset && !reset_req) begin
      for (int i = 0; i < N; i++) begin
        k = (mptr + i) % N;
        if (g < 0 && (m_read[k] || m_write[k])) g = k;
      end
    end
    s  = (g >= 0) ? g : mptr;
    a  = m_address[s*AW +: AW];
    be = m_byteenable[s*4 +: 4];
    d  = m_writedata[s*DW +: DW];
    wr = (g >= 0) && m_write[g];
    rd = (g >= 0) && !m_write[g] && m_read[g];
    exp_wait = 4'hF;
    if (g >= 0) exp_wait[g] = 1'b0;
    exp_rdv = '0;
    if (mrd_pend) exp_rdv[mrd_id] = 1'b1;
    chk("waitrequest", 32'(m_waitrequest), 32'(exp_wait));
    chk("chipselect", 32'(ram_chipselect), 32'(g >= 0));
    chk("ram_write", 32'(ram_write), 32'(wr));
    chk("clken", 32'(ram_clken), 32'(!reset_req));
    chk("ram_address", 32'(ram_address), 32'(a));
    if (g >= 0) begin
      chk("byteenable", 32'(ram_byteenable), 32'(be));
      chk("writedata", ram_writedata, d);
    end
    chk("readdatavalid", 32'(m_readdatavalid), 32'(exp_rdv));
    if (mrd_pend) chk("readdata", m_readdata, mrd_data);
    @(posedge clk);
    if (wr) ref_mem[a] = merge(ref_mem[a], d, be);
    if (g >= 0) mptr = (g + 1) % N;
    mrd_pend = rd;
    if (rd) begin
      mrd_id   = g;
      mrd_data = ref_mem[a];
    end
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    mptr     = 0;
    mrd_pend = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    mptr = 0; mrd_pend = 1'b0; mrd_id = 0; mrd_data = '0;
    #1;
    // Reset state, with requests pending that must not be granted
    m_read = 4'hF;
    do_reset();
    clear_req();

    // Master 2 full write then read back
    set_req(2, 1'b0, 1'b1, 12'h123, 4'hF, 32'hDEAD_BEEF);
    step();
    set_req(2, 1'b1, 1'b0, 12'h123, 4'hF, 32'h0);
    step();
    clear_req();
    #2;
    chk("rd_deadbeef", m_readdata, 32'hDEAD_BEEF);
    chk("rdv_master2", 32'(m_readdatavalid), 32'h4);
    step();
    step();

    // All four masters read continuously from reset
    do_reset();
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, 12'($urandom_range(0, 4095)), 4'hF, 32'h0);
      step();
    end
    clear_req();
    step();

    // Byte-lane write over a known word
    set_req(1, 1'b0, 1'b1, 12'h0A5, 4'hF, 32'h1122_3344);
    step();
    set_req(1, 1'b0, 1'b1, 12'h0A5, 4'b0010, 32'h0000_AB00);
    step();
    set_req(1, 1'b1, 1'b0, 12'h0A5, 4'hF, 32'h0);
    step();
    clear_req();
    #2;
    chk("byte_merge", m_readdata, 32'h1122_AB44);
    step();

    // Masters 0 and 3 with ptr=1: 3 first, then 0
    do_reset();
    set_req(0, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
    step();
    set_req(3, 1'b1, 1'b0, 12'h013, 4'hF, 32'h0);
    #2;
    chk("wait_m3_first", 32'(m_waitrequest), 32'b0111);
    step();
    step();
    clear_req();
    step();

    // reset_req pulse: pending read survives, grants blocked, resume on fall
    set_req(0, 1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
    step();
    reset_req = 1'b1;
    for (int c = 0; c < 3; c++) step();
    reset_req = 1'b0;
    #2;
    chk("resume_grant", 32'(m_waitrequest[0]), 32'h0);
    step();
    clear_req();
    step();

    // Reset the cycle after a read grant
    set_req(2, 1'b1, 1'b0, 12'h030, 4'hF, 32'h0);
    step();
    clear_req();
    do_reset();
    m_read = 4'hF;
    step();
    step();
    clear_req();
    step();

    // Random traffic over a small address window to exercise read-after-write
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N; k++) begin
        set_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                12'h200 + 12'($urandom_range(0, 15)), 4'($urandom), $urandom);
      end
      reset_req = ($urandom_range(0, 9) == 0);
      step();
    end
    reset_req = 1'b0;
    clear_req();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
